// File: rtl/hr_timer_pkg.sv
// Shared definitions for the interval-timer access sequencer: register map,
// control bits, request op encoding and sequencer state encoding.
package hr_timer_pkg;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_PERIODL = 3'd2;
    localparam logic [2:0] REG_PERIODH = 3'd3;
    localparam logic [2:0] REG_SNAPL   = 3'd4;
    localparam logic [2:0] REG_SNAPH   = 3'd5;

    localparam int unsigned CTL_ITO   = 0;
    localparam int unsigned CTL_CONT  = 1;
    localparam int unsigned CTL_START = 2;
    localparam int unsigned CTL_STOP  = 3;

    typedef enum logic [1:0] {
        OP_LOAD_START = 2'd0,
        OP_SNAPSHOT   = 2'd1,
        OP_STOP       = 2'd2,
        OP_CLR_TO     = 2'd3
    } op_t;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTL, S_WR_ST,
        S_SNAP_W, S_RD_L, S_RD_H, S_CAP_H, S_DONE
    } state_t;

    function automatic logic [15:0] ctl_word(logic start, logic stop, logic cont, logic ie);
        logic [15:0] w;
        w            = '0;
        w[CTL_ITO]   = ie;
        w[CTL_CONT]  = cont;
        w[CTL_START] = start;
        w[CTL_STOP]  = stop;
        return w;
    endfunction

endpackage

// File: rtl/hr_timer_access_sequencer_rr_arbiter.sv
// Round-robin requester pick; the search start pointer advances past the
// served requester when its sequence completes.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    input  logic [PTR_W-1:0]   done_idx,
    output logic               pick_valid_c,
    output logic [PTR_W-1:0]   pick_c
);

    localparam int unsigned SW = PTR_W + 1;

    logic [PTR_W-1:0] ptr;
    logic [SW-1:0]    idx;

    always_comb begin
        pick_valid_c = 1'b0;
        pick_c       = '0;
        idx          = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = SW'(ptr) + SW'(i);
            if (idx >= SW'(NUM_REQ)) begin
                idx = idx - SW'(NUM_REQ);
            end
            if (!pick_valid_c && req[idx[PTR_W-1:0]]) begin
                pick_valid_c = 1'b1;
                pick_c       = idx[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (done) begin
            ptr <= (done_idx == PTR_W'(NUM_REQ - 1)) ? '0 : done_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/hr_timer_access_sequencer.sv
// Shares one 16-bit interval-timer slave between NUM_REQ requesters, turning each
// granted request into a short sequence of registered slave accesses.
module hr_timer_access_sequencer
    import hr_timer_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [2*NUM_REQ-1:0]  op,
    input  logic [32*NUM_REQ-1:0] arg,
    input  logic                  cfg_continuous,
    input  logic                  cfg_irq_en,
    output logic [NUM_REQ-1:0]    ack,
    output logic [31:0]           result,
    output logic                  busy,
    output logic [2:0]            tmr_address,
    output logic                  tmr_chipselect,
    output logic                  tmr_write_n,
    output logic [15:0]           tmr_writedata,
    input  logic [15:0]           tmr_readdata
);

    state_t           state, state_n;
    logic [PTR_W-1:0] grant_q;
    op_t              op_q, sel_op, op_src;
    logic [31:0]      arg_q, sel_arg, arg_src;
    logic [15:0]      snap_lo;
    logic             pick_valid_c;
    logic [PTR_W-1:0] pick_c;
    logic             grant_ld;

    logic [2:0]         addr_n;
    logic               cs_n, wn_n;
    logic [15:0]        wd_n;
    logic [NUM_REQ-1:0] ack_n;
    logic [31:0]        result_n;
    logic               busy_n;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .done         (state == S_DONE),
        .done_idx     (grant_q),
        .pick_valid_c (pick_valid_c),
        .pick_c       (pick_c)
    );

    // Select the picked requester's op/arg fields.
    always_comb begin
        sel_op  = OP_LOAD_START;
        sel_arg = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_c == PTR_W'(i)) begin
                sel_op  = op_t'(op[2*i +: 2]);
                sel_arg = arg[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_n  = state;
        grant_ld = 1'b0;
        addr_n   = '0;
        cs_n     = 1'b0;
        wn_n     = 1'b1;
        wd_n     = '0;
        ack_n    = '0;
        result_n = '0;

        case (state)
            S_IDLE: begin
                if (pick_valid_c) begin
                    grant_ld = 1'b1;
                    case (sel_op)
                        OP_LOAD_START: state_n = S_WR_PL;
                        OP_SNAPSHOT:   state_n = S_SNAP_W;
                        OP_STOP:       state_n = S_WR_CTL;
                        default:       state_n = S_WR_ST;
                    endcase
                end
            end
            S_WR_PL:  state_n = S_WR_PH;
            S_WR_PH:  state_n = S_WR_CTL;
            S_WR_CTL: state_n = S_DONE;
            S_WR_ST:  state_n = S_DONE;
            S_SNAP_W: state_n = S_RD_L;
            S_RD_L:   state_n = S_RD_H;
            S_RD_H:   state_n = S_CAP_H;
            S_CAP_H:  state_n = S_DONE;
            default:  state_n = S_IDLE;
        endcase

        // On the grant cycle the latches are not yet loaded, so use the live fields.
        op_src  = grant_ld ? sel_op  : op_q;
        arg_src = grant_ld ? sel_arg : arg_q;

        case (state_n)
            S_WR_PL:  begin cs_n = 1'b1; wn_n = 1'b0; addr_n = REG_PERIODL; wd_n = arg_src[15:0];  end
            S_WR_PH:  begin cs_n = 1'b1; wn_n = 1'b0; addr_n = REG_PERIODH; wd_n = arg_src[31:16]; end
            S_WR_CTL: begin
                cs_n   = 1'b1;
                wn_n   = 1'b0;
                addr_n = REG_CONTROL;
                wd_n   = ctl_word(op_src == OP_LOAD_START, op_src == OP_STOP,
                                  cfg_continuous, cfg_irq_en);
            end
            S_WR_ST:  begin cs_n = 1'b1; wn_n = 1'b0; addr_n = REG_STATUS; end
            S_SNAP_W: begin cs_n = 1'b1; wn_n = 1'b0; addr_n = REG_SNAPL;  end
            S_RD_L:   begin cs_n = 1'b1; addr_n = REG_SNAPL; end
            S_RD_H:   begin cs_n = 1'b1; addr_n = REG_SNAPH; end
            default:  ;
        endcase

        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            ack_n[i] = (state_n == S_DONE) && (grant_q == PTR_W'(i));
        end
        if (state_n == S_DONE && op_q == OP_SNAPSHOT) begin
            result_n = {tmr_readdata, snap_lo};
        end
        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            tmr_address    <= '0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_writedata  <= '0;
            ack            <= '0;
            result         <= '0;
            busy           <= 1'b0;
            grant_q        <= '0;
            op_q           <= OP_LOAD_START;
            arg_q          <= '0;
            snap_lo        <= '0;
        end else begin
            state          <= state_n;
            tmr_address    <= addr_n;
            tmr_chipselect <= cs_n;
            tmr_write_n    <= wn_n;
            tmr_writedata  <= wd_n;
            ack            <= ack_n;
            result         <= result_n;
            busy           <= busy_n;
            if (grant_ld) begin
                grant_q <= pick_c;
                op_q    <= sel_op;
                arg_q   <= sel_arg;
            end
            // Low snapshot half arrives one cycle after the RD_L address.
            if (state == S_RD_H) begin
                snap_lo <= tmr_readdata;
            end
        end
    end

endmodule

// File: tb/tb_hr_timer_access_sequencer.sv
// Directed bench for the timer access sequencer with a registered-read timer slave model.
module tb_hr_timer_access_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [7:0]   op;
    logic [127:0] arg;
    logic         cfg_continuous, cfg_irq_en;
    logic [3:0]   ack;
    logic [31:0]  result;
    logic         busy;
    logic [2:0]   tmr_address;
    logic         tmr_chipselect, tmr_write_n;
    logic [15:0]  tmr_writedata;
    logic [15:0]  tmr_readdata = 16'h0;
    logic [15:0]  snap_lo_val = 16'h0, snap_hi_val = 16'h0;

    int checks = 0;
    int errors = 0;

    hr_timer_access_sequencer #(.NUM_REQ(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .op             (op),
        .arg            (arg),
        .cfg_continuous (cfg_continuous),
        .cfg_irq_en     (cfg_irq_en),
        .ack            (ack),
        .result         (result),
        .busy           (busy),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_readdata   (tmr_readdata)
    );

    always #5 clk = ~clk;

    // Timer slave: registered read data, one cycle after the address.
    always @(posedge clk) begin
        if (tmr_chipselect && tmr_write_n) begin
            case (tmr_address)
                3'd4:    tmr_readdata <= snap_lo_val;
                3'd5:    tmr_readdata <= snap_hi_val;
                default: tmr_readdata <= 16'h0;
            endcase
        end
    end

    wire [20:0] bus  = {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata};
    wire [57:0] outs = {ack, result, busy, bus};
    localparam logic [57:0] IDLE_OUTS = {4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0};
    localparam logic [20:0] BUS_IDLE  = {1'b0, 1'b1, 3'd0, 16'h0};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; req = '0; op = '0; arg = '0;
        cfg_continuous = 1'b0; cfg_irq_en = 1'b0;
        #2;
        checks++;
        if (outs !== IDLE_OUTS) begin errors++; $display("FAIL reset_async outs=%h exp=%h", outs, IDLE_OUTS); end
        tick;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick;
            checks++;
            if (outs !== IDLE_OUTS) begin errors++; $display("FAIL reset_idle_%0d outs=%h exp=%h", c, outs, IDLE_OUTS); end
        end
    endtask

    task automatic test_all_stop;
        logic [3:0] exp_ack;
        op = {4{2'd2}}; cfg_continuous = 1'b0; cfg_irq_en = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_ack = 4'b0001 << (k % 4);
            tick;
            checks++;
            if (bus !== {1'b1, 1'b0, 3'd1, 16'h0009} || busy !== 1'b1 || ack !== 4'h0) begin
                errors++; $display("FAIL stop_ctl_%0d bus=%h busy=%b ack=%b exp bus=%h", k, bus, busy, ack, {1'b1, 1'b0, 3'd1, 16'h0009});
            end
            tick;
            checks++;
            if (ack !== exp_ack || result !== 32'h0 || bus !== BUS_IDLE) begin
                errors++; $display("FAIL stop_ack_%0d ack=%b exp=%b bus=%h", k, ack, exp_ack, bus);
            end
            if (k == 4) req = 4'b0000;
            tick;
            checks++;
            if (ack !== 4'h0 || busy !== 1'b0) begin
                errors++; $display("FAIL stop_idle_%0d ack=%b busy=%b exp 0 0", k, ack, busy);
            end
        end
    endtask

    task automatic test_load_start;
        op[1:0] = 2'd0; arg[31:0] = 32'h0001_86A0;
        cfg_continuous = 1'b1; cfg_irq_en = 1'b1;
        req = 4'b0001;
        tick;
        checks++;
        if (bus !== {1'b1, 1'b0, 3'd2, 16'h86A0} || busy !== 1'b1) begin
            errors++; $display("FAIL load_pl bus=%h busy=%b exp=%h", bus, busy, {1'b1, 1'b0, 3'd2, 16'h86A0});
        end
        // Changes after grant must not leak into the sequence.
        arg[31:0] = 32'hFFFF_FFFF; op[1:0] = 2'd2;
        tick;
        checks++;
        if (bus !== {1'b1, 1'b0, 3'd3, 16'h0001}) begin errors++; $display("FAIL load_ph bus=%h exp=%h", bus, {1'b1, 1'b0, 3'd3, 16'h0001}); end
        tick;
        checks++;
        if (bus !== {1'b1, 1'b0, 3'd1, 16'h0007}) begin errors++; $display("FAIL load_ctl bus=%h exp=%h", bus, {1'b1, 1'b0, 3'd1, 16'h0007}); end
        tick;
        checks++;
        if (ack !== 4'b0001 || busy !== 1'b1 || result !== 32'h0 || bus !== BUS_IDLE) begin
            errors++; $display("FAIL load_ack ack=%b busy=%b result=%h bus=%h exp ack=0001", ack, busy, result, bus);
        end
        req = 4'b0000;
        tick;
        checks++;
        if (outs !== IDLE_OUTS) begin errors++; $display("FAIL load_idle outs=%h exp=%h", outs, IDLE_OUTS); end
    endtask

    task automatic test_snapshot;
        snap_lo_val = 16'h1234; snap_hi_val = 16'hABCD;
        op[5:4] = 2'd1;
        req = 4'b0100;
        tick;
        checks++;
        if (bus !== {1'b1, 1'b0, 3'd4, 16'h0}) begin errors++; $display("FAIL snap_w bus=%h exp=%h", bus, {1'b1, 1'b0, 3'd4, 16'h0}); end
        tick;
        checks++;
        if (bus !== {1'b1, 1'b1, 3'd4, 16'h0}) begin errors++; $display("FAIL snap_rdl bus=%h exp=%h", bus, {1'b1, 1'b1, 3'd4, 16'h0}); end
        tick;
        checks++;
        if (bus !== {1'b1, 1'b1, 3'd5, 16'h0}) begin errors++; $display("FAIL snap_rdh bus=%h exp=%h", bus, {1'b1, 1'b1, 3'd5, 16'h0}); end
        tick;
        checks++;
        if (bus !== BUS_IDLE || ack !== 4'h0 || busy !== 1'b1) begin
            errors++; $display("FAIL snap_cap bus=%h ack=%b busy=%b", bus, ack, busy);
        end
        tick;
        checks++;
        if (ack !== 4'b0100 || result !== 32'hABCD_1234) begin
            errors++; $display("FAIL snap_ack ack=%b result=%h exp 0100 abcd1234", ack, result);
        end
        req = 4'b0000;
        tick;
        checks++;
        if (outs !== IDLE_OUTS) begin errors++; $display("FAIL snap_idle outs=%h exp=%h", outs, IDLE_OUTS); end
    endtask

    task automatic test_clr_to_drop;
        // A request withdrawn before any clock edge sees it is never granted.
        req = 4'b1000;
        #2;
        req = 4'b0000;
        tick;
        checks++;
        if (busy !== 1'b0 || tmr_chipselect !== 1'b0) begin
            errors++; $display("FAIL early_drop busy=%b cs=%b exp 0 0", busy, tmr_chipselect);
        end
        op[3:2] = 2'd3;
        req = 4'b0010;
        tick;
        checks++;
        if (bus !== {1'b1, 1'b0, 3'd0, 16'h0}) begin errors++; $display("FAIL clr_wr bus=%h exp=%h", bus, {1'b1, 1'b0, 3'd0, 16'h0}); end
        req = 4'b0000;
        tick;
        checks++;
        if (ack !== 4'b0010 || result !== 32'h0) begin errors++; $display("FAIL clr_ack ack=%b result=%h exp 0010 0", ack, result); end
        tick;
        checks++;
        if (outs !== IDLE_OUTS) begin errors++; $display("FAIL clr_idle outs=%h exp=%h", outs, IDLE_OUTS); end
    endtask

    task automatic test_reset_abort;
        op[5:4] = 2'd1;
        req = 4'b0100;
        tick;
        tick;
        checks++;
        if (bus !== {1'b1, 1'b1, 3'd4, 16'h0}) begin errors++; $display("FAIL abort_rdl bus=%h exp=%h", bus, {1'b1, 1'b1, 3'd4, 16'h0}); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (outs !== IDLE_OUTS) begin errors++; $display("FAIL abort_async outs=%h exp=%h", outs, IDLE_OUTS); end
        req = 4'b0000; op[7:6] = 2'd2;
        cfg_continuous = 1'b1; cfg_irq_en = 1'b0;
        tick;
        checks++;
        if (outs !== IDLE_OUTS) begin errors++; $display("FAIL abort_hold outs=%h exp=%h", outs, IDLE_OUTS); end
        reset = 1'b0;
        req = 4'b1000;
        tick;
        checks++;
        if (bus !== {1'b1, 1'b0, 3'd1, 16'h000A}) begin errors++; $display("FAIL abort_regrant bus=%h exp=%h", bus, {1'b1, 1'b0, 3'd1, 16'h000A}); end
        tick;
        checks++;
        if (ack !== 4'b1000) begin errors++; $display("FAIL abort_ack ack=%b exp=1000", ack); end
        req = 4'b0000;
        tick;
        checks++;
        if (outs !== IDLE_OUTS) begin errors++; $display("FAIL abort_idle outs=%h exp=%h", outs, IDLE_OUTS); end
    endtask

    initial begin
        test_reset;
        test_all_stop;
        test_load_start;
        test_snapshot;
        test_clr_to_drop;
        test_reset_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
